nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/bitcoin_pkg.sv | 15 +
 rtl/nonce_result_buf.sv | 36 +++
 rtl/nonce_scheduler.sv | 147 ++++++++++++++
 tb/tb_nonce_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitcoin_pkg.sv
// Shared types and defaults for the nonce sweep scheduler and its result buffer.
package bitcoin_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_FINISH
  } state_t;

  localparam int DEF_NUM_NONCES = 16;
  localparam int DEF_NUM_CORES  = 4;

  typedef logic [31:0] word_t;
endpackage

// File: rtl/nonce_result_buf.sv
// Per-core result slots: a slot captures its core's hash once per batch and
// holds it, with a valid bit, until the scheduler clears the batch.
module nonce_result_buf import bitcoin_pkg::*; #(
  parameter int NUM_CORES = DEF_NUM_CORES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   capture_en,
  input  logic                   clear,
  input  logic [NUM_CORES-1:0]   launched,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [NUM_CORES*32-1:0] core_hash,
  output word_t                  slot_data [NUM_CORES],
  output logic [NUM_CORES-1:0]   slot_valid
);
  logic [NUM_CORES-1:0] capture;

  // First done from a launched core wins; repeats and unlaunched cores are dropped.
  assign capture = {NUM_CORES{capture_en}} & launched & core_done & ~slot_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
    end else if (clear) begin
      slot_valid <= '0;
    end else begin
      slot_valid <= slot_valid | capture;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (capture[i]) slot_data[i] <= core_hash[32*i +: 32];
    end
  end
endmodule

// File: rtl/nonce_scheduler.sv
// Sweeps NUM_NONCES nonces across NUM_CORES hash cores in batches and writes
// each batch's results to memory in ascending nonce order.
module nonce_scheduler import bitcoin_pkg::*; #(
  parameter int NUM_NONCES = DEF_NUM_NONCES,
  parameter int NUM_CORES  = DEF_NUM_CORES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*32-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_hash,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);
  localparam int BASE_W = 10;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t               state;
  logic [BASE_W-1:0]    base;
  logic [BASE_W-1:0]    base_next;
  logic [BASE_W-1:0]    issue_base;
  logic [15:0]          addr_q;
  logic [NUM_CORES-1:0] launched;
  logic [NUM_CORES-1:0] issue_mask;
  logic [CNT_W-1:0]     n_launch;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     wr_idx;
  logic                 buf_clear;
  logic                 all_valid;
  logic                 more_batches;
  logic                 do_issue;
  word_t                slot_data [NUM_CORES];
  logic [NUM_CORES-1:0] slot_valid;

  function automatic logic [CNT_W-1:0] launch_count(input logic [BASE_W-1:0] b);
    int rem;
    rem = NUM_NONCES - int'(b);
    if (rem >= NUM_CORES) return CNT_W'(NUM_CORES);
    return CNT_W'(rem);
  endfunction

  always_comb begin
    base_next  = base + BASE_W'(NUM_CORES);
    issue_base = (state == ST_IDLE) ? '0 : base_next;
    issue_cnt  = launch_count(issue_base);
    issue_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      issue_mask[i] = (CNT_W'(i) < issue_cnt);
    end
  end

  assign all_valid    = ((slot_valid & launched) == launched);
  assign buf_clear    = (state == ST_WRITE) && (wr_idx == n_launch);
  assign more_batches = (base_next < BASE_W'(NUM_NONCES));
  assign do_issue     = ((state == ST_IDLE) && start) || (buf_clear && more_batches);

  nonce_result_buf #(.NUM_CORES(NUM_CORES)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (state == ST_WAIT),
    .clear      (buf_clear),
    .launched   (launched),
    .core_done  (core_done),
    .core_hash  (core_hash),
    .slot_data  (slot_data),
    .slot_valid (slot_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      base           <= '0;
      addr_q         <= '0;
      launched       <= '0;
      n_launch       <= '0;
      wr_idx         <= '0;
      done           <= 1'b0;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= output_addr;
            base   <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          core_start <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Slot 0 is presented on entry so mem_we lines up with the WRITE state.
          if (all_valid) begin
            state          <= ST_WRITE;
            mem_we         <= 1'b1;
            mem_addr       <= addr_q + 16'(base);
            mem_write_data <= slot_data[0];
            wr_idx         <= CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (buf_clear) begin
            mem_we <= 1'b0;
            base   <= base_next;
            if (more_batches) begin
              state <= ST_ISSUE;
            end else begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end else begin
            mem_we         <= 1'b1;
            mem_addr       <= addr_q + 16'(base) + 16'(wr_idx);
            mem_write_data <= slot_data[wr_idx[IDX_W-1:0]];
            wr_idx         <= wr_idx + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Launch pulses are registered so they coincide with the ISSUE state.
      if (do_issue) begin
        core_start <= issue_mask;
        launched   <= issue_mask;
        n_launch   <= issue_cnt;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (issue_mask[i]) core_nonce[32*i +: 32] <= 32'(issue_base) + 32'(i);
        end
      end
    end
  end
endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: three configurations driven by modelled hash cores
// with per-core latency, hash = nonce ^ 32'hA5A5A5A5.
module tb_nonce_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start  [3];
  logic [15:0]  oaddr  [3];
  logic         done   [3];
  logic [3:0]   cstart [3];
  logic [127:0] cnonce [3];
  logic [3:0]   cdone  [3];
  logic [127:0] chash  [3];
  logic         we     [3];
  logic [15:0]  maddr  [3];
  logic [31:0]  wdata  [3];

  nonce_scheduler #(.NUM_NONCES(16), .NUM_CORES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .output_addr(oaddr[0]),
    .done(done[0]), .core_start(cstart[0]), .core_nonce(cnonce[0]),
    .core_done(cdone[0]), .core_hash(chash[0]), .mem_we(we[0]),
    .mem_addr(maddr[0]), .mem_write_data(wdata[0]));

  nonce_scheduler #(.NUM_NONCES(6), .NUM_CORES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .output_addr(oaddr[1]),
    .done(done[1]), .core_start(cstart[1]), .core_nonce(cnonce[1]),
    .core_done(cdone[1]), .core_hash(chash[1]), .mem_we(we[1]),
    .mem_addr(maddr[1]), .mem_write_data(wdata[1]));

  nonce_scheduler #(.NUM_NONCES(4), .NUM_CORES(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .output_addr(oaddr[2]),
    .done(done[2]), .core_start(cstart[2]), .core_nonce(cnonce[2]),
    .core_done(cdone[2]), .core_hash(chash[2]), .mem_we(we[2]),
    .mem_addr(maddr[2]), .mem_write_data(wdata[2]));

  // Core model: done fires lat[i] cycles after the launch pulse is seen.
  int lat [4];
  int cnt [3][4];
  initial begin
    for (int d = 0; d < 3; d++) begin
      cdone[d] = '0;
      chash[d] = '0;
      for (int i = 0; i < 4; i++) cnt[d][i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 4; i++) begin
          cdone[d][i] = 1'b0;
          if (cnt[d][i] > 0) begin
            cnt[d][i] = cnt[d][i] - 1;
            if (cnt[d][i] == 0) begin
              cdone[d][i] = 1'b1;
              chash[d][32*i +: 32] = cnonce[d][32*i +: 32] ^ 32'hA5A5A5A5;
            end
          end
          if (cstart[d][i]) cnt[d][i] = lat[i];
        end
      end
    end
  end

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [31:0] w;
  } wr_t;
  wr_t wlog[$];
  int  done_cnt [3]    = '{default: 0};
  int  cs_cnt   [3][4] = '{default: '{default: 0}};

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (we[d]) wlog.push_back('{d, maddr[d], wdata[d]});
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
      for (int i = 0; i < 4; i++) begin
        if (cstart[d][i]) cs_cnt[d][i] <= cs_cnt[d][i] + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int d, input string name);
    check(name, {done[d], we[d], maddr[d], wdata[d], cstart[d]}, 64'd0);
    check({name, "_nonce"}, 64'(|cnonce[d]), 64'd0);
  endtask

  task automatic set_lat(input int mode);
    if (mode == 0) lat = '{3, 3, 3, 3};
    else           lat = '{4, 2, 4, 1};  // finish order 3,1, then 0 and 2 together
  endtask

  task automatic run_job(input int d, input logic [15:0] a);
    int guard;
    int d0;
    d0 = done_cnt[d];
    @(posedge clk); #1;
    oaddr[d] = a;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    guard = 0;
    while (done_cnt[d] == d0 && guard < 600) begin
      @(posedge clk);
      guard++;
    end
    check("job_timeout", 64'(guard < 600), 64'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input int w0, input int d, input logic [15:0] a0, input int n);
    logic [15:0] ea;
    check("write_count", 64'(wlog.size() - w0), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (w0 + k < wlog.size()) begin
        ea = a0 + 16'(k);
        check("write_inst", 64'(wlog[w0+k].d), 64'(d));
        check("write_addr", 64'(wlog[w0+k].a), 64'(ea));
        check("write_data", 64'(wlog[w0+k].w), 64'(32'(k) ^ 32'hA5A5A5A5));
      end
    end
  endtask

  typedef struct {
    int          d;
    logic [15:0] addr;
    int          mode;
    int          exp_writes;
    int          exp_batches;
    int          exp_hi_starts;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int w0;
    int d0;
    int cs0;
    int c20;
    int c30;
    int guard;

    vecs[0] = '{0, 16'h0100, 0, 16, 4, 4};
    vecs[1] = '{0, 16'h0200, 1, 16, 4, 4};
    vecs[2] = '{1, 16'h0300, 0,  6, 2, 1};
    vecs[3] = '{2, 16'hFFFE, 0,  4, 1, 1};
    vecs[4] = '{1, 16'h0040, 1,  6, 2, 1};
    vecs[5] = '{0, 16'hFFF8, 0, 16, 4, 4};

    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      oaddr[d] = '0;
    end
    set_lat(0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    check_zero(2, "reset_c");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 6; v++) begin
      set_lat(vecs[v].mode);
      w0  = wlog.size();
      d0  = done_cnt[vecs[v].d];
      cs0 = cs_cnt[vecs[v].d][0];
      c20 = cs_cnt[vecs[v].d][2];
      c30 = cs_cnt[vecs[v].d][3];
      run_job(vecs[v].d, vecs[v].addr);
      check_writes(w0, vecs[v].d, vecs[v].addr, vecs[v].exp_writes);
      check("done_count", 64'(done_cnt[vecs[v].d] - d0), 64'd1);
      check("issue_count", 64'(cs_cnt[vecs[v].d][0] - cs0), 64'(vecs[v].exp_batches));
      check("core2_starts", 64'(cs_cnt[vecs[v].d][2] - c20), 64'(vecs[v].exp_hi_starts));
      check("core3_starts", 64'(cs_cnt[vecs[v].d][3] - c30), 64'(vecs[v].exp_hi_starts));
    end

    // start pulsed repeatedly while a job is running must not queue a second job
    set_lat(0);
    w0 = wlog.size();
    d0 = done_cnt[0];
    @(posedge clk); #1;
    oaddr[0] = 16'h0500;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    guard = 0;
    while (done_cnt[0] == d0 && guard < 600) begin
      @(posedge clk); #1;
      guard++;
      start[0] = (guard % 3 == 0);
    end
    start[0] = 1'b0;
    check("busy_timeout", 64'(guard < 600), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    check_writes(w0, 0, 16'h0500, 16);
    check("busy_done_count", 64'(done_cnt[0] - d0), 64'd1);

    // reset while batch 2 waits on its cores
    w0  = wlog.size();
    d0  = done_cnt[0];
    cs0 = cs_cnt[0][0];
    @(posedge clk); #1;
    oaddr[0] = 16'h0700;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    guard = 0;
    while (cs_cnt[0][0] - cs0 < 2 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("batch2_timeout", 64'(guard < 600), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_zero(0, "midjob_reset");
    check("midjob_writes", 64'(wlog.size() - w0), 64'd4);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_writes", 64'(wlog.size() - w0), 64'd4);
    check("post_reset_done", 64'(done_cnt[0] - d0), 64'd0);

    w0 = wlog.size();
    d0 = done_cnt[0];
    run_job(0, 16'h0800);
    check_writes(w0, 0, 16'h0800, 16);
    check("clean_done_count", 64'(done_cnt[0] - d0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
